// File: rtl/mig7_arb_pkg.sv
// Shared constants and FSM state type for the MIG7 user-interface arbiter.
package mig7_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_WAIT_CAL,
    ST_ARB,
    ST_WR_ISSUE,
    ST_RD_ISSUE
  } arb_state_e;

endpackage

// File: rtl/mig7_arb_tag_fifo.sv
// Outstanding-read tag FIFO: remembers which requester owns each in-flight read.
module mig7_arb_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_pop,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_tag   = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tag;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/mig7_arb.sv
// Round-robin arbiter sharing one MIG7 user interface among NREQ requesters.
// Optional per-requester grant counters are built when MIG7_ARB_STATS_EN is defined.
//
// state       | meaning
// WAIT_CAL    | memory not calibrated, no grants
// ARB         | pick next eligible requester round-robin
// WR_ISSUE    | drive write command and write data until both accepted
// RD_ISSUE    | drive read command until accepted, then record owner tag
module mig7_arb
  import mig7_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_init_calib_complete,
  input  logic [NREQ-1:0]             i_req_valid,
  input  logic [NREQ-1:0]             i_req_write,
  input  logic [NREQ-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0] i_req_wdata,
  input  logic [NREQ-1:0][MASK_W-1:0] i_req_mask,
  output logic [NREQ-1:0]             o_req_ready,
  output logic [NREQ-1:0]             o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic [ADDR_W-1:0]           o_app_addr,
  output logic [2:0]                  o_app_cmd,
  output logic                        o_app_en,
  output logic [DATA_W-1:0]           o_app_wdf_data,
  output logic                        o_app_wdf_end,
  output logic [MASK_W-1:0]           o_app_wdf_mask,
  output logic                        o_app_wdf_wren,
  output logic                        o_app_sr_req,
  output logic                        o_app_ref_req,
  output logic                        o_app_zq_req,
  input  logic [DATA_W-1:0]           i_app_rd_data,
  input  logic                        i_app_rd_data_end,
  input  logic                        i_app_rd_data_valid,
  input  logic                        i_app_rdy,
  input  logic                        i_app_wdf_rdy,
  output logic                        o_busy,
  output logic                        o_err_underflow
`ifdef MIG7_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][31:0]       o_stat_grants
`endif
);

  localparam int TAG_W = $clog2(NREQ);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [TAG_W-1:0]  r_rr_ptr;
  logic [TAG_W-1:0]  r_grant_idx;
  logic [TAG_W-1:0]  w_grant_idx;
  logic              w_grant_vld;
  logic              w_grant_fire;
  logic [NREQ-1:0]   w_eligible;
  logic              r_cmd_done;
  logic              r_data_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_mask;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_err_underflow;
  logic              w_push;
  logic [TAG_W-1:0]  w_fifo_tag;
  logic              w_full;
  logic              w_empty;
  logic              w_unused;

  // Each beat carries a whole 128-bit word, so the end-of-burst marker adds nothing.
  assign w_unused = i_app_rd_data_end;

  mig7_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_tag   (r_grant_idx),
    .i_pop   (i_app_rd_data_valid),
    .o_tag   (w_fifo_tag),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Reads wait while the tag FIFO is full; writes are never held back by it.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_eligible[i] = i_req_valid[i] & (i_req_write[i] | ~w_full);
    end
  end

  always_comb begin
    logic [TAG_W:0] v_sum;
    v_sum       = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
      if (v_sum >= (TAG_W+1)'(NREQ)) v_sum = v_sum - (TAG_W+1)'(NREQ);
      if (!w_grant_vld && w_eligible[v_sum[TAG_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_sum[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_req_ready    = '0;
    o_app_en       = 1'b0;
    o_app_cmd      = APP_CMD_WRITE;
    o_app_wdf_wren = 1'b0;
    o_app_wdf_end  = 1'b0;
    w_push         = 1'b0;
    w_grant_fire   = 1'b0;
    case (r_state)
      ST_WAIT_CAL: begin
        if (i_init_calib_complete) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (!i_init_calib_complete) begin
          w_state_nxt = ST_WAIT_CAL;
        end else if (w_grant_vld) begin
          w_grant_fire             = 1'b1;
          o_req_ready[w_grant_idx] = 1'b1;
          w_state_nxt = i_req_write[w_grant_idx] ? ST_WR_ISSUE : ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        o_app_en       = ~r_cmd_done;
        o_app_wdf_wren = ~r_data_done;
        o_app_wdf_end  = ~r_data_done;
        if ((r_cmd_done | i_app_rdy) && (r_data_done | i_app_wdf_rdy)) begin
          w_state_nxt = i_init_calib_complete ? ST_ARB : ST_WAIT_CAL;
        end
      end
      ST_RD_ISSUE: begin
        o_app_en  = 1'b1;
        o_app_cmd = APP_CMD_READ;
        if (i_app_rdy) begin
          w_push      = 1'b1;
          w_state_nxt = i_init_calib_complete ? ST_ARB : ST_WAIT_CAL;
        end
      end
      default: w_state_nxt = ST_WAIT_CAL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_WAIT_CAL;
      r_rr_ptr        <= '0;
      r_grant_idx     <= '0;
      r_cmd_done      <= 1'b0;
      r_data_done     <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_mask          <= '0;
      r_rsp_valid     <= '0;
      r_rsp_data      <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_fire) begin
        r_rr_ptr    <= (w_grant_idx == TAG_W'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;
        r_grant_idx <= w_grant_idx;
        r_addr      <= i_req_addr[w_grant_idx];
        r_wdata     <= i_req_wdata[w_grant_idx];
        r_mask      <= i_req_mask[w_grant_idx];
        r_cmd_done  <= 1'b0;
        r_data_done <= 1'b0;
      end
      if (r_state == ST_WR_ISSUE) begin
        if (o_app_en && i_app_rdy)           r_cmd_done  <= 1'b1;
        if (o_app_wdf_wren && i_app_wdf_rdy) r_data_done <= 1'b1;
      end
      r_rsp_valid <= '0;
      if (i_app_rd_data_valid) begin
        if (!w_empty) begin
          r_rsp_valid[w_fifo_tag] <= 1'b1;
          r_rsp_data              <= i_app_rd_data;
        end else begin
          r_err_underflow <= 1'b1;
        end
      end
    end
  end

`ifdef MIG7_ARB_STATS_EN
  logic [NREQ-1:0][31:0] r_stat_grants;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_grants <= '0;
    end else if (w_grant_fire) begin
      r_stat_grants[w_grant_idx] <= r_stat_grants[w_grant_idx] + 32'd1;
    end
  end

  assign o_stat_grants = r_stat_grants;
`endif

  assign o_app_addr      = r_addr;
  assign o_app_wdf_data  = r_wdata;
  assign o_app_wdf_mask  = r_mask;
  assign o_app_sr_req    = 1'b0;
  assign o_app_ref_req   = 1'b0;
  assign o_app_zq_req    = 1'b0;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_err_underflow = r_err_underflow;
  assign o_busy          = (r_state != ST_ARB) | ~w_empty;

endmodule

// File: tb/tb_mig7_arb.sv
// Directed bench for mig7_arb: calibration hold, round-robin writes, split write
// handshake, tag FIFO saturation, read response routing and underflow.
module tb_mig7_arb;
  import mig7_arb_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib = 1'b0;
  logic [NREQ-1:0]             req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0][MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] rsp_data, app_wdf_data, rd_data;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic [MASK_W-1:0] app_wdf_mask;
  logic app_en, app_wdf_end, app_wdf_wren, app_sr_req, app_ref_req, app_zq_req;
  logic rd_end, rd_valid, app_rdy, wdf_rdy, busy, err_underflow;

  int n_cmp = 0;
  int n_err = 0;
  int cnt, cnt2;
  int seq [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  mig7_arb #(.NREQ(NREQ), .TAG_DEPTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_calib_complete(calib),
    .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_mask(req_mask), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_app_addr(app_addr),
    .o_app_cmd(app_cmd), .o_app_en(app_en), .o_app_wdf_data(app_wdf_data),
    .o_app_wdf_end(app_wdf_end), .o_app_wdf_mask(app_wdf_mask),
    .o_app_wdf_wren(app_wdf_wren), .o_app_sr_req(app_sr_req),
    .o_app_ref_req(app_ref_req), .o_app_zq_req(app_zq_req),
    .i_app_rd_data(rd_data), .i_app_rd_data_end(rd_end),
    .i_app_rd_data_valid(rd_valid), .i_app_rdy(app_rdy), .i_app_wdf_rdy(wdf_rdy),
    .o_busy(busy), .o_err_underflow(err_underflow)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    req_valid = '0; req_write = '0;
    rd_data = '0; rd_end = 1'b0; rd_valid = 1'b0;
    app_rdy = 1'b1; wdf_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i]  = ADDR_W'(32'h100 * (i + 1));
      req_wdata[i] = {4{32'hC0DE_0000 + 32'(i)}};
      req_mask[i]  = MASK_W'(16'h0001 << i);
    end

    // reset state
    cyc(); cyc();
    check("rst_app_en", app_en, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_err", err_underflow, 0);
    check("rst_busy", busy, 1);
    check("rst_app_addr", app_addr, 0);
    check("rst_wren", app_wdf_wren, 0);
    check("rst_wdf_data", app_wdf_data, 0);
    check("rst_tied", {app_sr_req, app_ref_req, app_zq_req}, 0);

    // no activity before calibration
    rst = 1'b0; req_valid = 4'hF; req_write = 4'hF; cnt = 0;
    repeat (100) begin
      cyc();
      if (req_ready != 0 || app_en) cnt++;
    end
    check("cal_hold_activity", cnt, 0);

    // round-robin writes 0,1,2,3,0, two cycles each
    calib = 1'b1;
    cyc();
    for (int j = 0; j < 5; j++) begin
      check("rr_ready", req_ready, 128'(1) << seq[j]);
      cyc();
      check("wr_app_en", app_en, 1);
      check("wr_cmd", app_cmd, 3'b000);
      check("wr_wren_end", {app_wdf_wren, app_wdf_end}, 2'b11);
      check("wr_addr", app_addr, req_addr[seq[j]]);
      check("wr_data", app_wdf_data, req_wdata[seq[j]]);
      check("wr_mask", app_wdf_mask, req_mask[seq[j]]);
      if (j == 4) req_valid = '0;
      cyc();
    end
    check("rr_idle_ready", req_ready, 0);

    // command accepted at cycle 1, data only at cycle 4
    req_valid = 4'b0010; req_write = 4'b0010;
    #1;
    check("split_ready", req_ready, 4'b0010);
    cyc();
    req_valid = '0; cnt = 0; cnt2 = 0;
    for (int k = 1; k <= 6; k++) begin
      app_rdy = (k == 1); wdf_rdy = (k == 4);
      #1;
      if (app_en) cnt++;
      if (app_wdf_wren) cnt2++;
      cyc();
    end
    check("split_app_en_cycles", cnt, 1);
    check("split_wren_cycles", cnt2, 4);
    check("split_busy_after", busy, 0);
    app_rdy = 1'b1; wdf_rdy = 1'b1;

    // 17 reads from requester 2 with no data returned
    req_valid = 4'b0100; req_write = '0;
    #1;
    check("rd_first_ready", req_ready, 4'b0100);
    cnt = 0; cnt2 = 0;
    for (int c = 0; c < 60; c++) begin
      if (req_ready[2]) cnt++;
      if (app_en && app_cmd == APP_CMD_READ) cnt2++;
      cyc();
    end
    check("rd_accepted", cnt, 16);
    check("rd_issued", cnt2, 16);
    check("rd_busy", busy, 1);

    req_valid = 4'b0101; req_write = 4'b0001;
    #1;
    check("full_write_grant", req_ready, 4'b0001);
    cyc();
    check("full_write_cmd", {app_en, app_cmd}, 4'b1000);
    check("full_write_addr", app_addr, req_addr[0]);
    req_valid = 4'b0100; req_write = '0;
    cyc();
    check("full_read_blocked", req_ready, 0);

    // pop while full: no admission that cycle, admission next cycle
    rd_valid = 1'b1; rd_data = 128'h55;
    #1;
    check("full_pop_same_cycle", req_ready, 0);
    cyc();
    rd_valid = 1'b0;
    check("pop_rsp_valid", rsp_valid, 4'b0100);
    check("pop_rsp_data", rsp_data, 128'h55);
    #1;
    check("refill_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    check("refill_cmd", {app_en, app_cmd}, 4'b1001);
    cyc();

    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1; rd_data = 128'(32'h1000 + i);
      cyc();
      check("drain_rsp_valid", rsp_valid, 4'b0100);
      check("drain_rsp_data", rsp_data, 128'(32'h1000 + i));
    end
    rd_valid = 1'b0;
    cyc();
    check("drain_rsp_idle", rsp_valid, 0);
    check("drain_busy", busy, 0);
    check("drain_err", err_underflow, 0);

    // reads from 1 then 3, responses routed in order
    req_valid = 4'b0010;
    #1;
    check("rd1_ready", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'b1000;
    #1;
    check("rd3_ready", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    cyc();
    rd_valid = 1'b1; rd_data = {4{32'hAAAA_AAAA}};
    cyc();
    check("rsp1_valid", rsp_valid, 4'b0010);
    check("rsp1_data", rsp_data, {4{32'hAAAA_AAAA}});
    rd_data = {4{32'hBBBB_BBBB}};
    cyc();
    check("rsp3_valid", rsp_valid, 4'b1000);
    check("rsp3_data", rsp_data, {4{32'hBBBB_BBBB}});
    rd_valid = 1'b0;
    cyc();
    check("rsp_idle", rsp_valid, 0);
    check("no_err_yet", err_underflow, 0);

    // underflow with nothing outstanding
    rd_valid = 1'b1; rd_data = 128'hC;
    cyc();
    rd_valid = 1'b0;
    check("uf_rsp_valid", rsp_valid, 0);
    check("uf_err", err_underflow, 1);
    cyc(); cyc();
    check("uf_err_sticky", err_underflow, 1);
    check("uf_rsp_quiet", rsp_valid, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("uf_err_cleared", err_underflow, 0);
    check("post_rst_busy", busy, 1);

    // calibration loss during an issue: finish it, then hold
    cyc();
    req_valid = 4'b0001; req_write = 4'b0001;
    #1;
    check("cal_drop_ready", req_ready, 4'b0001);
    cyc();
    calib = 1'b0; req_valid = '0;
    check("cal_drop_finish", app_en, 1);
    cyc();
    check("cal_drop_busy", busy, 1);
    check("cal_drop_app_en", app_en, 0);
    req_valid = 4'b0001;
    #1;
    check("cal_drop_no_grant", req_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mig7_arb.md
MIG7_ARB -- requirements
Module: mig7_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the MIG7 user interface (2..8).
REQ-002 Parameter TAG_DEPTH, default 16, outstanding-read tag FIFO depth (power of two).
REQ-003 clk  in  1  MIG7 ui_clk; all logic is single-clock.
REQ-004 rst  in  1  synchronous active-high reset (MIG7 ui_clk_sync_rst).
REQ-005 init_calib_complete  in  1  MIG7 calibration done.
REQ-006 req_valid / req_write  in  NREQ each  request present / 1=write, 0=read.
REQ-007 req_addr [NREQ][28], req_wdata [NREQ][128], req_mask [NREQ][16]  in  per-requester address, write data, byte mask.
REQ-008 req_ready  out  NREQ  one-cycle accept strobe.
REQ-009 rsp_valid  out  NREQ  read data strobe to the owning requester.
REQ-010 rsp_data  out  128  read data, shared.
REQ-011 app_addr(28), app_cmd(3), app_en, app_wdf_data(128), app_wdf_end, app_wdf_mask(16), app_wdf_wren, app_sr_req, app_ref_req, app_zq_req  out  MIG7 user interface.
REQ-012 app_rd_data(128), app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy  in  MIG7 user interface.
REQ-013 busy  out  1  FSM not in ARB or tags outstanding; err_underflow  out  1  sticky error.

Function
REQ-014 FSM states WAIT_CAL, ARB, WR_ISSUE, RD_ISSUE; WAIT_CAL->ARB when init_calib_complete=1.
REQ-015 ARB: round-robin grant among req_valid, starting at (last granted index + 1) mod NREQ; index 0 has first priority after reset.
REQ-016 A read request is eligible only when the tag FIFO is not full; ineligible reads are skipped without blocking writes.
REQ-017 On grant: req_ready[i]=1 for exactly that cycle; addr/data/mask/write registered; next state WR_ISSUE or RD_ISSUE.
REQ-018 WR_ISSUE: app_en=1, app_cmd=000, app_wdf_wren=1, app_wdf_end=1; command drops after cycle with app_rdy=1, data drops after cycle with app_wdf_rdy=1, independently; ARB once both accepted.
REQ-019 RD_ISSUE: app_en=1, app_cmd=001 until app_rdy=1; tag i pushed in that acceptance cycle; then ARB.
REQ-020 Issue latency: app_en asserted the cycle after req_ready; minimum 2 cycles per request.
REQ-021 On app_rd_data_valid: pop tag t, rsp_valid[t]=1 and rsp_data=app_rd_data registered, one cycle later; no response backpressure.
REQ-022 Push and pop in the same cycle leave occupancy unchanged; full with simultaneous pop does not admit a new read that cycle.
REQ-023 app_rd_data_valid with empty FIFO: no rsp_valid, err_underflow set until reset.
REQ-024 init_calib_complete falling: finish current issue, then WAIT_CAL; tags retained.
REQ-025 app_sr_req, app_ref_req, app_zq_req tied 0.

Reset
REQ-026 rst=1: state WAIT_CAL, RR pointer 0, tag FIFO empty, all strobes/app_en/app_wdf_wren/rsp_valid/err_underflow 0, data outputs 0.
REQ-027 Reset mid-transaction abandons the transaction; pending read data after reset is treated per REQ-023.

Configuration
REQ-028 Macro MIG7_ARB_STATS_EN defined: per-requester 32-bit wrapping grant counters, output stat_grants [NREQ][32], cleared by rst; undefined: port and counters absent, behaviour otherwise identical.

Structure
REQ-029 Package mig7_arb_pkg: APP_CMD_WRITE=3'b000, APP_CMD_READ=3'b001, address/data/mask width constants, FSM state enum.
REQ-030 Sub-module mig7_arb_tag_fifo: synchronous FIFO of $clog2(NREQ)-bit tags, full/empty flags.

Verification
REQ-031 Hold init_calib_complete=0, all req_valid=1 -> no req_ready, app_en=0 for 100 cycles.
REQ-032 All four requesters write continuously, app_rdy=app_wdf_rdy=1 -> grants 0,1,2,3,0 in order, one per 2 cycles.
REQ-033 Write with app_rdy=1 at cycle 1, app_wdf_rdy=1 only at cycle 4 -> app_en 1 cycle, app_wdf_wren 4 cycles, single write.
REQ-034 17 reads from requester 2, no read data returned -> 16 accepted, 17th stalls; requester 0 write still granted.
REQ-035 Reads from 1 then 3, two app_rd_data_valid with 0xA.., 0xB.. -> rsp_valid[1] with 0xA.., then rsp_valid[3] with 0xB...
REQ-036 app_rd_data_valid with no reads outstanding -> err_underflow=1 sticky, rsp_valid stays 0.
